// File: rtl/dpc_manual_bp_scanner.sv
// Manual bad-point table scanner: walks a sorted {row,col} table in BRAM in step with the
// raster and flags matching pixels; blocks table writes while a frame is being scanned.
module dpc_manual_bp_scanner #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned COORD_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [ADDR_WIDTH:0]     bp_count,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [COORD_W-1:0]      pix_x,
    input  logic [COORD_W-1:0]      pix_y,
    input  logic                    cfg_we,
    input  logic [ADDR_WIDTH-1:0]   cfg_addr,
    input  logic [2*COORD_W-1:0]    cfg_data,
    output logic                    cfg_ready,
    output logic                    bram_ena,
    output logic                    bram_wea,
    output logic [ADDR_WIDTH-1:0]   bram_addra,
    output logic [2*COORD_W-1:0]    bram_dina,
    output logic                    bram_enb,
    output logic [ADDR_WIDTH-1:0]   bram_addrb,
    input  logic [2*COORD_W-1:0]    bram_doutb,
    output logic                    bad_valid,
    output logic                    bad_flag,
    output logic                    err_skip,
    output logic                    err_prime
);

    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam int unsigned KeyW = 2 * COORD_W;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StPrime0,
        StPrime1,
        StActive,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [KeyW-1:0]   cur_q, cur_d;
    logic              bad_valid_q, bad_valid_d;
    logic              bad_flag_q, bad_flag_d;
    logic              err_skip_q, err_skip_d;
    logic              err_prime_q, err_prime_d;

    logic [KeyW-1:0]   pix_key;
    logic [CntW-1:0]   idx_inc;
    logic [CntW-1:0]   addr_next;
    logic              scanning;

    assign pix_key  = {pix_y, pix_x};
    assign idx_inc  = idx_q + CntW'(1);
    assign scanning = (state_q == StPrime0) || (state_q == StPrime1) || (state_q == StActive);

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        bad_valid_d = pix_valid;
        bad_flag_d  = 1'b0;
        err_skip_d  = err_skip_q;
        err_prime_d = err_prime_q;

        if (frame_start) begin
            // Restart from any state; configuration is latched only here.
            idx_d   = '0;
            cnt_d   = (bp_count > DepthC) ? DepthC : bp_count;
            state_d = (!enable || (bp_count == '0)) ? StDone : StPrime0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                end
                StPrime0: begin
                    if (pix_valid) err_prime_d = 1'b1;
                    state_d = StPrime1;
                end
                StPrime1: begin
                    if (pix_valid) err_prime_d = 1'b1;
                    cur_d   = bram_doutb;
                    state_d = StActive;
                end
                StActive: begin
                    if (pix_valid && (pix_key >= cur_q)) begin
                        bad_flag_d = (pix_key == cur_q);
                        if (pix_key != cur_q) err_skip_d = 1'b1;
                        idx_d = idx_inc;
                        cur_d = bram_doutb;
                        if (idx_inc == cnt_q) state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Port B lookahead: doutb must hold entry idx+1 one cycle from now.
    always_comb begin
        addr_next = '0;
        unique case (state_q)
            StPrime1: addr_next = CntW'(1);
            StActive: addr_next = idx_d + CntW'(1);
            default:  addr_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            cur_q       <= '0;
            bad_valid_q <= 1'b0;
            bad_flag_q  <= 1'b0;
            err_skip_q  <= 1'b0;
            err_prime_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            bad_valid_q <= bad_valid_d;
            bad_flag_q  <= bad_flag_d;
            err_skip_q  <= err_skip_d;
            err_prime_q <= err_prime_d;
        end
    end

    // Held low during reset so a write cannot slip through before the scanner is alive.
    assign cfg_ready  = rst_n && ((state_q == StIdle) || (state_q == StDone));
    assign bram_ena   = cfg_we && cfg_ready;
    assign bram_wea   = cfg_we && cfg_ready;
    assign bram_addra = cfg_addr;
    assign bram_dina  = cfg_data;
    assign bram_enb   = scanning;
    // Index cnt wraps to address 0 here; that read is never used.
    assign bram_addrb = addr_next[ADDR_WIDTH-1:0];

    assign bad_valid  = bad_valid_q;
    assign bad_flag   = bad_flag_q;
    assign err_skip   = err_skip_q;
    assign err_prime  = err_prime_q;

endmodule
